// File: rtl/result_readout_pkg.sv
// Shared types and constants for the result SRAM readout stage.
// Imported by the readout FSM and the word serializer.
package result_readout_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_FIN
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_BYTE_W = 8;
  localparam int BYTES_PER_WORD = DEF_DATA_W / DEF_BYTE_W;

  localparam logic CS_ACTIVE = 1'b0;
  localparam logic WE_READ   = 1'b1;

  function automatic int bytes_per_word(
    input int data_w,
    input int byte_w
  );
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/result_readout_if.sv
// SRAM read port plus byte-stream valid/ready bundle.
// master = readout stage, slave = SRAM model / stream consumer.
interface result_readout_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8
);

  logic              ram_cs_n;
  logic              ram_we_n;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_ry;
  logic [DATA_W-1:0] ram_rdata;
  logic [BYTE_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    output ram_cs_n,
    output ram_we_n,
    output ram_address,
    input  ram_ry,
    input  ram_rdata,
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  ram_cs_n,
    input  ram_we_n,
    input  ram_address,
    output ram_ry,
    output ram_rdata,
    input  dout,
    input  dout_valid,
    output dout_ready
  );

endinterface

// File: rtl/result_readout_word_serializer.sv
// Shifts one loaded word out MSB byte first over valid/ready.
// last pulses in the cycle the final byte is accepted.
module word_serializer
  import result_readout_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic [BYTE_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              last
);

  localparam int BPW   = bytes_per_word(DATA_W, BYTE_W);
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              valid;
  logic              fire;

  assign fire       = valid & dout_ready;
  assign last       = fire && (cnt == CNT_W'(BPW - 1));
  assign dout_valid = valid;
  assign dout       = valid ? shreg[DATA_W-1 -: BYTE_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      shreg <= data;
      cnt   <= '0;
      valid <= 1'b1;
    end else if (fire) begin
      shreg <= shreg << BYTE_W;
      if (last) begin
        cnt   <= '0;
        valid <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/result_readout.sv
// Reads NUM_WORDS SRAM words from BASE_ADDR, streams them as bytes
// and tracks the unsigned maximum word of the pass.
module result_readout
  import result_readout_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int BYTE_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int NUM_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  result_readout_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] max_word
);

  localparam int WC_W = ADDR_W + 1;

  state_t            state;
  logic [WC_W-1:0]   word_cnt;
  logic [ADDR_W-1:0] addr;
  logic              cs_n;
  logic              load;
  logic              last;

  assign load            = (state == S_WAIT) && bus.ram_ry;
  assign bus.ram_cs_n    = cs_n;
  assign bus.ram_we_n    = WE_READ;
  assign bus.ram_address = addr;

  word_serializer #(
    .DATA_W(DATA_W),
    .BYTE_W(BYTE_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data      (bus.ram_rdata),
    .dout      (bus.dout),
    .dout_valid(bus.dout_valid),
    .dout_ready(bus.dout_ready),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      word_cnt <= '0;
      addr     <= '0;
      cs_n     <= ~CS_ACTIVE;
      busy     <= 1'b0;
      done     <= 1'b0;
      max_word <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= S_REQ;
            addr     <= ADDR_W'(BASE_ADDR);
            word_cnt <= '0;
            max_word <= '0;
            cs_n     <= CS_ACTIVE;
            busy     <= 1'b1;
          end
        end
        S_REQ: begin
          cs_n  <= ~CS_ACTIVE;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.ram_ry) begin
            if (bus.ram_rdata > max_word)
              max_word <= bus.ram_rdata;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (last) begin
            if (word_cnt == WC_W'(NUM_WORDS - 1)) begin
              state <= S_FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              word_cnt <= word_cnt + WC_W'(1);
              addr     <= addr + ADDR_W'(1);
              cs_n     <= CS_ACTIVE;
              state    <= S_REQ;
            end
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
